// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the readback decoder.
// Segments are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  // Indexed by nibble value.
  localparam seg7_t SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } cap_state_e;

endpackage

// File: rtl/seg7_lookup.sv
// Reverse 7-segment lookup: pattern -> nibble.
// Any pattern missing from the table yields nibble 0 with err set.
module seg7_lookup
  import seg7_pkg::*;
(
  input  seg7_t      seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_TABLE[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures a multiplexed active-low 7-segment bus, deglitches each digit,
// decodes it and presents the assembled word on a valid/ready handshake.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  seg7_t             seg,
  input  logic [NDIG-1:0]   digit_sel,
  output logic [4*NDIG-1:0] out_value,
  output logic [NDIG-1:0]   out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int CW = (STABLE_CYCLES > 1) ?
                      $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [NDIG+6:0]   hist_q, hist_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_q, acc_d;
  cap_state_e        state_q, state_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] hold_val_q, hold_val_d;
  logic [NDIG-1:0]   hold_err_q, hold_err_d;
  logic [4*NDIG-1:0] out_value_q, out_value_d;
  logic [NDIG-1:0]   out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  logic [3:0] dec_nib;
  logic       dec_err;
  logic       onehot;
  logic       stable;
  logic       fire;

  seg7_lookup u_lookup (
    .seg    (seg),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  always_comb begin
    onehot = $onehot(digit_sel);
    stable = onehot && ({digit_sel, seg} == hist_q);
    fire   = stable && (cnt_q == CMAX) && !acc_q;
    hist_d = {digit_sel, seg};
    cnt_d  = '0;
    acc_d  = 1'b0;
    if (stable) begin
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
      acc_d = acc_q | fire;
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    hold_val_d  = hold_val_q;
    hold_err_d  = hold_err_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      COLLECT: begin
        if (fire) begin
          for (int i = 0; i < NDIG; i++) begin
            if (digit_sel[i]) begin
              hold_val_d[4*i +: 4] = dec_nib;
              hold_err_d[i]        = dec_err;
              seen_d[i]            = 1'b1;
            end
          end
          if (&seen_d) begin
            state_d     = PRESENT;
            out_valid_d = 1'b1;
            out_value_d = hold_val_d;
            out_err_d   = hold_err_d;
          end
        end
      end
      PRESENT: begin
        // Nowhere to put a digit while the word waits.
        if (fire) overrun_d = 1'b1;
        if (out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
          seen_d      = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      state_q     <= COLLECT;
      seen_q      <= '0;
      hold_val_q  <= '0;
      hold_err_q  <= '0;
      out_value_q <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      seen_q      <= seen_d;
      hold_val_q  <= hold_val_d;
      hold_err_q  <= hold_err_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_value = out_value_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: frame vectors from a table plus
// hand-written glitch, overrun, bad-strobe and async-reset sequences.
module tb_seg7_capture_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int pass_cnt = 0;
  int total    = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  seg7_capture_decoder #(
    .NDIG          (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg       (seg),
    .digit_sel (digit_sel),
    .out_value (out_value),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [3:0][6:0] s;
    logic [15:0]     val;
    logic [3:0]      err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: compare every completed handshake against the queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", {12'h0, out_err, out_value}, 32'hFFFFFFFF);
      end else begin
        check("sb_word", {12'h0, out_err, out_value}, {12'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic hold(input logic [3:0] sel, input logic [6:0] s,
                      input int n);
    digit_sel = sel;
    seg       = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic frame(input vec_t v);
    for (int d = 0; d < 4; d++) begin
      hold(4'b0001 << d, v.s[d], 6);
      if (d < 3) check("valid_early", {31'h0, out_valid}, 32'h0);
    end
  endtask

  initial begin
    vecs[0] = '{s: {7'h30, 7'h24, 7'h79, 7'h40}, val: 16'h3210, err: 4'b0000};
    vecs[1] = '{s: {7'h78, 7'h02, 7'h12, 7'h19}, val: 16'h7654, err: 4'b0000};
    vecs[2] = '{s: {7'h03, 7'h08, 7'h10, 7'h00}, val: 16'hBA98, err: 4'b0000};
    vecs[3] = '{s: {7'h0E, 7'h06, 7'h21, 7'h46}, val: 16'hFEDC, err: 4'b0000};
    vecs[4] = '{s: {7'h21, 7'h7F, 7'h03, 7'h08}, val: 16'hD0BA, err: 4'b0100};
    vecs[5] = '{s: {7'h7F, 7'h55, 7'h01, 7'h40}, val: 16'h0000, err: 4'b1110};

    reset_n   = 1'b0;
    out_ready = 1'b0;
    digit_sel = 4'b0000;
    seg       = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", {16'h0, out_value}, 32'h0);
    check("rst_err", {28'h0, out_err}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames.
    foreach (vecs[k]) begin
      frame(vecs[k]);
      check("frame_valid", {31'h0, out_valid}, 32'h1);
      check("frame_value", {16'h0, out_value}, {16'h0, vecs[k].val});
      check("frame_err", {28'h0, out_err}, {28'h0, vecs[k].err});
      sb_q.push_back({vecs[k].err, vecs[k].val});
      handshake();
    end

    // Bouncing digit 0 must not be captured; only the settled E counts.
    hold(4'b0010, 7'h79, 6);
    hold(4'b0100, 7'h24, 6);
    hold(4'b1000, 7'h30, 6);
    for (int t = 0; t < 5; t++) begin
      hold(4'b0001, 7'h40, 2);
      hold(4'b0001, 7'h79, 2);
    end
    check("glitch_no_accept", {31'h0, out_valid}, 32'h0);
    hold(4'b0001, 7'h06, 5);
    check("glitch_valid", {31'h0, out_valid}, 32'h1);
    check("glitch_value", {16'h0, out_value}, 32'h321E);
    sb_q.push_back({4'b0000, 16'h321E});
    handshake();

    // A long hold completes the word once; a second accept would overrun.
    hold(4'b0001, 7'h46, 6);
    hold(4'b0010, 7'h21, 6);
    hold(4'b0100, 7'h06, 6);
    hold(4'b1000, 7'h0E, 20);
    check("long_valid", {31'h0, out_valid}, 32'h1);
    check("long_single", {31'h0, overrun}, 32'h0);
    check("long_value", {16'h0, out_value}, 32'hFEDC);
    sb_q.push_back({4'b0000, 16'hFEDC});
    handshake();

    // Zero and multi-hot strobes never accept.
    hold(4'b0011, 7'h40, 10);
    hold(4'b0000, 7'h40, 10);
    hold(4'b0010, 7'h79, 6);
    hold(4'b0100, 7'h24, 6);
    hold(4'b1000, 7'h30, 6);
    check("badsel_no_word", {31'h0, out_valid}, 32'h0);
    hold(4'b0001, 7'h40, 6);
    check("badsel_valid", {31'h0, out_valid}, 32'h1);
    check("badsel_value", {16'h0, out_value}, 32'h3210);
    sb_q.push_back({4'b0000, 16'h3210});
    handshake();

    // Overrun while a word waits.
    frame(vecs[1]);
    check("ovr_valid", {31'h0, out_valid}, 32'h1);
    sb_q.push_back({4'b0000, 16'h7654});
    hold(4'b0001, 7'h46, 6);
    check("ovr_set", {31'h0, overrun}, 32'h1);
    check("ovr_value_kept", {16'h0, out_value}, 32'h7654);
    handshake();
    frame(vecs[0]);
    check("ovr_next_value", {16'h0, out_value}, 32'h3210);
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    sb_q.push_back({4'b0000, 16'h3210});
    handshake();

    // Async reset mid-frame discards the partial word.
    hold(4'b0001, 7'h19, 6);
    hold(4'b0010, 7'h12, 6);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_value", {16'h0, out_value}, 32'h0);
    check("arst_overrun", {31'h0, overrun}, 32'h0);
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(4'b0010, 7'h12, 6);
    hold(4'b0100, 7'h02, 6);
    hold(4'b1000, 7'h78, 6);
    check("arst_partial", {31'h0, out_valid}, 32'h0);
    hold(4'b0001, 7'h19, 6);
    check("arst_valid_after", {31'h0, out_valid}, 32'h1);
    check("arst_value_after", {16'h0, out_value}, 32'h7654);
    sb_q.push_back({4'b0000, 16'h7654});
    handshake();

    check("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
